// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - encodings and control-word widths for the pipeline controller
package riscv_pipe_pkg;

  // WB result mux select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // ALU operand source select
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int RESSRC_W = 2;
  localparam int ALUCTL_W = 3;

  // Control bits per stage, register indices excluded
  localparam int IDEX_CTRL_W  = 1 + RESSRC_W + 1 + 1 + 1 + ALUCTL_W + 1;
  localparam int EXMEM_CTRL_W = 1 + RESSRC_W + 1;
  localparam int MEMWB_CTRL_W = 1 + RESSRC_W;

  // The younger (MEM) producer wins over the older (WB) one
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    if (hit_m) return FWD_MEM;
    if (hit_w) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_ctrl_reg.sv
// rtl/pipe_ctrl_reg.sv - pipeline register with load enable and synchronous clear
module pipe_ctrl_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold when en is low; clr loads a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - control pipeline, forwarding, stall/flush and stall counter
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwrite_d,
  input  logic [1:0]        resultsrc_d,
  input  logic              memwrite_d,
  input  logic              jump_d,
  input  logic              branch_d,
  input  logic [2:0]        alucontrol_d,
  input  logic              alusrc_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              zero_e,
  input  logic              mem_ready,
  output logic [2:0]        alucontrol_e,
  output logic              alusrc_e,
  output logic              pcsrc_e,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              memwrite_m,
  output logic              mem_req_m,
  output logic              regwrite_w,
  output logic [1:0]        resultsrc_w,
  output logic [REG_AW-1:0] rd_w,
  output logic              stall_fd,
  output logic              flush_d,
  output logic              flush_e,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int IDEX_W  = IDEX_CTRL_W + 3 * REG_AW;
  localparam int EXMEM_W = EXMEM_CTRL_W + REG_AW;
  localparam int MEMWB_W = MEMWB_CTRL_W + REG_AW;

  logic [IDEX_W-1:0]  idex_d, idex_q;
  logic [EXMEM_W-1:0] exmem_d, exmem_q;
  logic [MEMWB_W-1:0] memwb_d, memwb_q;

  logic              regwrite_e, memwrite_e, jump_e, branch_e;
  logic [1:0]        resultsrc_e;
  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
  logic              regwrite_m;
  logic [1:0]        resultsrc_m;
  logic [REG_AW-1:0] rd_m;

  logic mem_stall, lw_stall, advance;
  logic hit_a_m, hit_a_w, hit_b_m, hit_b_w;

  assign idex_d = {regwrite_d, resultsrc_d, memwrite_d, jump_d, branch_d,
                   alucontrol_d, alusrc_d, rs1_d, rs2_d, rd_d};
  assign {regwrite_e, resultsrc_e, memwrite_e, jump_e, branch_e,
          alucontrol_e, alusrc_e, rs1_e, rs2_e, rd_e} = idex_q;

  assign exmem_d = {regwrite_e, resultsrc_e, memwrite_e, rd_e};
  assign {regwrite_m, resultsrc_m, memwrite_m, rd_m} = exmem_q;

  assign memwb_d = {regwrite_m, resultsrc_m, rd_m};
  assign {regwrite_w, resultsrc_w, rd_w} = memwb_q;

  // A pending data-memory access freezes every stage
  assign advance = ~mem_stall;

  pipe_ctrl_reg #(.W(IDEX_W)) u_idex (
    .clk(clk), .rst_n(rst_n), .en(advance), .clr(flush_e), .d(idex_d), .q(idex_q)
  );

  pipe_ctrl_reg #(.W(EXMEM_W)) u_exmem (
    .clk(clk), .rst_n(rst_n), .en(advance), .clr(1'b0), .d(exmem_d), .q(exmem_q)
  );

  pipe_ctrl_reg #(.W(MEMWB_W)) u_memwb (
    .clk(clk), .rst_n(rst_n), .en(advance), .clr(1'b0), .d(memwb_d), .q(memwb_q)
  );

  assign pcsrc_e   = (branch_e & zero_e) | jump_e;
  assign mem_req_m = memwrite_m | (resultsrc_m == RES_MEM);
  assign mem_stall = mem_req_m & ~mem_ready;
  assign lw_stall  = (resultsrc_e == RES_MEM) & (rd_e != '0) &
                     ((rd_e == rs1_d) | (rd_e == rs2_d));

  // Forwarding selects; x0 never forwards
  always_comb begin
    hit_a_m     = regwrite_m & (rd_m != '0) & (rd_m == rs1_e);
    hit_a_w     = regwrite_w & (rd_w != '0) & (rd_w == rs1_e);
    hit_b_m     = regwrite_m & (rd_m != '0) & (rd_m == rs2_e);
    hit_b_w     = regwrite_w & (rd_w != '0) & (rd_w == rs2_e);
    forward_a_e = fwd_sel(hit_a_m, hit_a_w);
    forward_b_e = fwd_sel(hit_b_m, hit_b_w);
  end

  // Stall/flush; a memory wait overrides load-use and control-flow hazards
  always_comb begin
    stall_fd = lw_stall;
    flush_d  = pcsrc_e;
    flush_e  = lw_stall | pcsrc_e;
    if (mem_stall) begin
      stall_fd = 1'b1;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
    end
  end

  // Saturating count of front-end stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall_fd && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  import riscv_pipe_pkg::*;

  logic clk, rst_n;
  logic regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d, zero_e, mem_ready;
  logic [1:0] resultsrc_d;
  logic [2:0] alucontrol_d;
  logic [4:0] rs1_d, rs2_d, rd_d;

  logic [2:0] alucontrol_e, s_alucontrol_e;
  logic alusrc_e, pcsrc_e, memwrite_m, mem_req_m, regwrite_w, stall_fd, flush_d, flush_e;
  logic s_alusrc_e, s_pcsrc_e, s_memwrite_m, s_mem_req_m, s_regwrite_w, s_stall_fd, s_flush_d, s_flush_e;
  logic [1:0] forward_a_e, forward_b_e, resultsrc_w, s_forward_a_e, s_forward_b_e, s_resultsrc_w;
  logic [4:0] rd_w, s_rd_w;
  logic [15:0] stall_cycles;
  logic [1:0] s_stall_cycles;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .regwrite_d(regwrite_d), .resultsrc_d(resultsrc_d),
    .memwrite_d(memwrite_d), .jump_d(jump_d), .branch_d(branch_d), .alucontrol_d(alucontrol_d),
    .alusrc_d(alusrc_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .zero_e(zero_e),
    .mem_ready(mem_ready), .alucontrol_e(alucontrol_e), .alusrc_e(alusrc_e), .pcsrc_e(pcsrc_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .memwrite_m(memwrite_m),
    .mem_req_m(mem_req_m), .regwrite_w(regwrite_w), .resultsrc_w(resultsrc_w), .rd_w(rd_w),
    .stall_fd(stall_fd), .flush_d(flush_d), .flush_e(flush_e), .stall_cycles(stall_cycles)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .regwrite_d(regwrite_d), .resultsrc_d(resultsrc_d),
    .memwrite_d(memwrite_d), .jump_d(jump_d), .branch_d(branch_d), .alucontrol_d(alucontrol_d),
    .alusrc_d(alusrc_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .zero_e(zero_e),
    .mem_ready(mem_ready), .alucontrol_e(s_alucontrol_e), .alusrc_e(s_alusrc_e), .pcsrc_e(s_pcsrc_e),
    .forward_a_e(s_forward_a_e), .forward_b_e(s_forward_b_e), .memwrite_m(s_memwrite_m),
    .mem_req_m(s_mem_req_m), .regwrite_w(s_regwrite_w), .resultsrc_w(s_resultsrc_w), .rd_w(s_rd_w),
    .stall_fd(s_stall_fd), .flush_d(s_flush_d), .flush_e(s_flush_e), .stall_cycles(s_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rw; logic [1:0] res; logic mw, j, b; logic [2:0] alu; logic as;
    logic [4:0] rs1, rs2, rd;
  } instr_t;

  typedef struct {
    instr_t i; logic z, rdy;
    logic pc; logic [1:0] fa, fb; logic mreq, rww; logic [4:0] rdw;
    logic st, fd, fe; int cnt;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl[23];
  instr_t pipe[3];   // reference pipeline: [0]=EX, [1]=MEM, [2]=WB
  int mcnt;

  function automatic instr_t ins(logic rw, logic [1:0] res, logic mw, logic j, logic b,
                                 logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
    instr_t t;
    t.rw = rw; t.res = res; t.mw = mw; t.j = j; t.b = b;
    t.alu = rd[2:0]; t.as = 1'b0; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    return t;
  endfunction

  function automatic vec_t mkv(instr_t i, logic z, logic rdy, logic pc, logic [1:0] fa,
                               logic [1:0] fb, logic mreq, logic rww, logic [4:0] rdw,
                               logic st, logic fd, logic fe, int cnt);
    vec_t v;
    v.i = i; v.z = z; v.rdy = rdy; v.pc = pc; v.fa = fa; v.fb = fb; v.mreq = mreq;
    v.rww = rww; v.rdw = rdw; v.st = st; v.fd = fd; v.fe = fe; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input instr_t i, input logic z, input logic r);
    regwrite_d = i.rw; resultsrc_d = i.res; memwrite_d = i.mw; jump_d = i.j; branch_d = i.b;
    alucontrol_d = i.alu; alusrc_d = i.as; rs1_d = i.rs1; rs2_d = i.rs2; rd_d = i.rd;
    zero_e = z; mem_ready = r;
  endtask

  function automatic logic [1:0] mfwd(logic [4:0] rs);
    if (pipe[1].rw && pipe[1].rd != 0 && pipe[1].rd == rs) return 2'b10;
    if (pipe[2].rw && pipe[2].rd != 0 && pipe[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  logic [37:0] all_outs;
  assign all_outs = {alucontrol_e, alusrc_e, pcsrc_e, forward_a_e, forward_b_e, memwrite_m,
                     mem_req_m, regwrite_w, resultsrc_w, rd_w, stall_fd, flush_d, flush_e,
                     stall_cycles};
  logic [21:0] s_outs;
  assign s_outs = {s_alucontrol_e, s_alusrc_e, s_pcsrc_e, s_forward_a_e, s_forward_b_e,
                   s_memwrite_m, s_mem_req_m, s_regwrite_w, s_resultsrc_w, s_rd_w,
                   s_stall_fd, s_flush_d, s_flush_e};

  initial begin
    instr_t nop, id;
    logic z, rdy, mreq, mst, lw, pc, st, fd, fe;
    logic [21:0] exp_s;
    nop = ins(0, 0, 0, 0, 0, 0, 0, 0);

    //                in                               z  r  pc fa fb mr rw rd st fd fe cnt
    tbl[0]  = mkv(ins(1, 0, 0, 0, 0, 0, 0, 1),         0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(ins(1, 0, 0, 0, 0, 1, 2, 3),         0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(ins(1, 0, 0, 0, 0, 3, 3, 4),         0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mkv(ins(1, 0, 0, 0, 0, 3, 4, 6),         0, 1, 0, 2, 2, 0, 1, 1, 0, 0, 0, 0);
    tbl[4]  = mkv(ins(1, 0, 0, 0, 0, 6, 0, 0),         0, 1, 0, 1, 2, 0, 1, 3, 0, 0, 0, 0);
    tbl[5]  = mkv(ins(1, 0, 0, 0, 0, 0, 0, 7),         0, 1, 0, 2, 0, 0, 1, 4, 0, 0, 0, 0);
    tbl[6]  = mkv(ins(1, 1, 0, 0, 0, 0, 0, 5),         0, 1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0);
    tbl[7]  = mkv(ins(1, 0, 0, 0, 0, 1, 5, 8),         0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0);
    tbl[8]  = mkv(ins(1, 0, 0, 0, 0, 1, 5, 8),         0, 1, 0, 0, 0, 1, 1, 7, 0, 0, 0, 1);
    tbl[9]  = mkv(ins(0, 0, 0, 0, 1, 0, 0, 0),         0, 1, 0, 0, 1, 0, 1, 5, 0, 0, 0, 1);
    tbl[10] = mkv(ins(1, 0, 0, 0, 0, 0, 0, 9),         1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    tbl[11] = mkv(ins(0, 0, 0, 0, 1, 0, 0, 0),         1, 1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 1);
    tbl[12] = mkv(ins(1, 2, 0, 1, 0, 0, 0, 1),         0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[13] = mkv(nop,                                 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    tbl[14] = mkv(ins(0, 0, 1, 0, 0, 0, 1, 0),         0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[15] = mkv(ins(1, 1, 0, 0, 0, 0, 0, 2),         0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1);
    tbl[16] = mkv(nop,                                 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1);
    tbl[17] = mkv(nop,                                 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2);
    tbl[18] = mkv(nop,                                 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 3);
    tbl[19] = mkv(nop,                                 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4);
    tbl[20] = mkv(nop,                                 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 4);
    tbl[21] = mkv(nop,                                 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5);
    tbl[22] = mkv(nop,                                 0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 5);

    // Reset held for three cycles
    drive(nop, 0, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outs", 64'(all_outs), 0);
    chk("reset_sat_cnt", 64'(s_stall_cycles), 0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_outs", 64'(all_outs), 0);

    // Directed program table
    for (int k = 0; k < 23; k++) begin
      @(negedge clk);
      drive(tbl[k].i, tbl[k].z, tbl[k].rdy);
      #2;
      chk($sformatf("row%0d pcsrc_e", k), 64'(pcsrc_e), 64'(tbl[k].pc));
      chk($sformatf("row%0d forward_a_e", k), 64'(forward_a_e), 64'(tbl[k].fa));
      chk($sformatf("row%0d forward_b_e", k), 64'(forward_b_e), 64'(tbl[k].fb));
      chk($sformatf("row%0d mem_req_m", k), 64'(mem_req_m), 64'(tbl[k].mreq));
      chk($sformatf("row%0d regwrite_w", k), 64'(regwrite_w), 64'(tbl[k].rww));
      chk($sformatf("row%0d rd_w", k), 64'(rd_w), 64'(tbl[k].rdw));
      chk($sformatf("row%0d stall_fd", k), 64'(stall_fd), 64'(tbl[k].st));
      chk($sformatf("row%0d flush_d", k), 64'(flush_d), 64'(tbl[k].fd));
      chk($sformatf("row%0d flush_e", k), 64'(flush_e), 64'(tbl[k].fe));
      chk($sformatf("row%0d stall_cycles", k), 64'(stall_cycles), 64'(tbl[k].cnt));
    end

    // Counter saturation with a long memory wait, then asynchronous reset mid-stall
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(ins(1, 1, 0, 0, 0, 0, 0, 2), 0, 1);
    @(negedge clk);
    drive(nop, 0, 1);
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      drive(nop, 0, 0);
      #2;
      chk($sformatf("sat%0d stall_fd", n), 64'(stall_fd), 1);
      chk($sformatf("sat%0d mem_req_m", n), 64'(mem_req_m), 1);
      chk($sformatf("sat%0d stall_cycles", n), 64'(stall_cycles), 64'(n));
      chk($sformatf("sat%0d sat_cycles", n), 64'(s_stall_cycles), 64'((n > 3) ? 3 : n));
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 64'(all_outs), 0);
    chk("async_reset_sat_outs", 64'({s_outs, s_stall_cycles}), 0);

    // Randomized stimulus against the reference pipeline
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) pipe[s] = nop;
    mcnt = 0;
    for (int c = 0; c < 400; c++) begin
      id = ins(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
               1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 4) == 0), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      id.alu = 3'($urandom_range(0, 7));
      id.as  = 1'($urandom_range(0, 1));
      z   = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 3) != 0);
      @(negedge clk);
      drive(id, z, rdy);
      #2;
      mreq = pipe[1].mw || (pipe[1].res == 2'b01);
      mst  = mreq && !rdy;
      lw   = (pipe[0].res == 2'b01) && (pipe[0].rd != 0) &&
             ((pipe[0].rd == id.rs1) || (pipe[0].rd == id.rs2));
      pc   = (pipe[0].b && z) || pipe[0].j;
      st   = mst || lw;
      fd   = !mst && pc;
      fe   = !mst && (lw || pc);
      chk($sformatf("rand%0d alucontrol_e", c), 64'(alucontrol_e), 64'(pipe[0].alu));
      chk($sformatf("rand%0d alusrc_e", c), 64'(alusrc_e), 64'(pipe[0].as));
      chk($sformatf("rand%0d pcsrc_e", c), 64'(pcsrc_e), 64'(pc));
      chk($sformatf("rand%0d forward_a_e", c), 64'(forward_a_e), 64'(mfwd(pipe[0].rs1)));
      chk($sformatf("rand%0d forward_b_e", c), 64'(forward_b_e), 64'(mfwd(pipe[0].rs2)));
      chk($sformatf("rand%0d memwrite_m", c), 64'(memwrite_m), 64'(pipe[1].mw));
      chk($sformatf("rand%0d mem_req_m", c), 64'(mem_req_m), 64'(mreq));
      chk($sformatf("rand%0d regwrite_w", c), 64'(regwrite_w), 64'(pipe[2].rw));
      chk($sformatf("rand%0d resultsrc_w", c), 64'(resultsrc_w), 64'(pipe[2].res));
      chk($sformatf("rand%0d rd_w", c), 64'(rd_w), 64'(pipe[2].rd));
      chk($sformatf("rand%0d stall_fd", c), 64'(stall_fd), 64'(st));
      chk($sformatf("rand%0d flush_d", c), 64'(flush_d), 64'(fd));
      chk($sformatf("rand%0d flush_e", c), 64'(flush_e), 64'(fe));
      chk($sformatf("rand%0d stall_cycles", c), 64'(stall_cycles),
          64'((mcnt > 65535) ? 65535 : mcnt));
      chk($sformatf("rand%0d sat_cycles", c), 64'(s_stall_cycles), 64'((mcnt > 3) ? 3 : mcnt));
      exp_s = {pipe[0].alu, pipe[0].as, pc, mfwd(pipe[0].rs1), mfwd(pipe[0].rs2), pipe[1].mw,
               mreq, pipe[2].rw, pipe[2].res, pipe[2].rd, st, fd, fe};
      chk($sformatf("rand%0d sat_outs", c), 64'(s_outs), 64'(exp_s));
      if (!mst) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = fe ? nop : id;
      end
      if (st) mcnt++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
